// File: rtl/conv_pool_pkg.sv
// conv_pool_pipe shared types and helpers.
// FSM state enum, accumulator width helper, pixel clamp.
package conv_pool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int CLAMP_W = 64;

  function automatic int acc_width(
    input int pix_w,
    input int kw,
    input int nch
  );
    return pix_w + kw + 5 + $clog2(nch);
  endfunction

  function automatic logic [31:0] clamp_pix(
    input logic signed [CLAMP_W-1:0] v,
    input int                        pix_w
  );
    logic signed [CLAMP_W-1:0] hi;
    hi = (64'sd1 <<< pix_w) - 64'sd1;
    if (v <= 0) return '0;
    if (v >= hi) return hi[31:0];
    return v[31:0];
  endfunction

endpackage

// File: rtl/conv_pool_if.sv
// conv_pool_pipe bus: control, tile/kernel inputs,
// read requests and pooled pixel writes.
interface conv_pool_if #(
  parameter int NCH    = 3,
  parameter int PIX_W  = 8,
  parameter int KW     = 8,
  parameter int ADDR_W = 16
);
  logic                    start;
  logic                    stall;
  logic [NCH*16*PIX_W-1:0] image;
  logic [NCH*9*KW-1:0]     kernel;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [PIX_W-1:0]        y;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, stall, image, kernel,
    output rd_en, rd_addr, wr_en, wr_addr,
    output y, busy, done
  );

  modport master (
    output start, stall, image, kernel,
    input  rd_en, rd_addr, wr_en, wr_addr,
    input  y, busy, done
  );
endinterface

// File: rtl/conv_pool_pipe_conv3x3_chan.sv
// One channel: 4x4 tile x signed 3x3 kernel ->
// four signed partial sums (outputs (0,0),(0,1),(1,0),(1,1)).
module conv3x3_chan
  import conv_pool_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int KW    = 8,
  parameter int ACC_W = acc_width(8, 8, 3)
) (
  input  logic [16*PIX_W-1:0] tile,
  input  logic [9*KW-1:0]     kern,
  output logic [4*ACC_W-1:0]  part
);
  localparam int PW = PIX_W + KW + 1;

  logic signed [PW-1:0]    px;
  logic signed [PW-1:0]    kc;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;

  // pixel is zero-extended, coefficient sign-extended
  always_comb begin
    part = '0;
    px   = '0;
    kc   = '0;
    prod = '0;
    acc  = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc = '0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            px   = PW'(tile[((r+i)*4+c+j)*PIX_W +: PIX_W]);
            kc   = PW'(signed'(kern[(r*3+c)*KW +: KW]));
            prod = px * kc;
            acc  = acc + ACC_W'(prod);
          end
        end
        part[(i*2+j)*ACC_W +: ACC_W] = acc;
      end
    end
  end

endmodule

// File: rtl/conv_pool_pipe.sv
// Pipelined conv/clamp/pool tile engine, one tile per cycle.
// CONV_POOL_MAX_POOL_EN: max pooling instead of average.
module conv_pool_pipe
  import conv_pool_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int PIX_W     = 8,
  parameter int KW        = 8,
  parameter int ADDR_W    = 16,
  parameter int NUM_TILES = 65025
) (
  input logic        clk,
  input logic        rst,
  conv_pool_if.slave bus
);
  localparam int ACC_W = acc_width(PIX_W, KW, NCH);
  localparam int IMG_W = NCH * 16 * PIX_W;
  localparam int PRT_W = NCH * 4 * ACC_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_TILES - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               v0_q, v0_d, v1_q, v1_d;
  logic               v2_q, v2_d, v3_q, v3_d;
  logic [ADDR_W-1:0]  a0_q, a0_d, a1_q, a1_d;
  logic [ADDR_W-1:0]  a2_q, a2_d, a3_q, a3_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic [PRT_W-1:0]   part_q, part_d, part_w;
  logic [PIX_W-1:0]   y_q, y_d, pool_w;
  logic               rd_go;

  // stage 2 datapath: per-channel 3x3 MACs off the S1 image
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    conv3x3_chan #(
      .PIX_W(PIX_W),
      .KW   (KW),
      .ACC_W(ACC_W)
    ) u_chan (
      .tile(img_q[ch*16*PIX_W +: 16*PIX_W]),
      .kern(bus.kernel[ch*9*KW +: 9*KW]),
      .part(part_w[ch*4*ACC_W +: 4*ACC_W])
    );
  end

  logic signed [ACC_W-1:0] sum;
  logic [PIX_W-1:0]        cl [4];
`ifndef CONV_POOL_MAX_POOL_EN
  logic [PIX_W+1:0]        tot;
`endif

  // stages 3/4 datapath: channel sum, clamp, 2x2 pool
  always_comb begin
    sum    = '0;
    cl     = '{default: '0};
    pool_w = '0;
    for (int o = 0; o < 4; o++) begin
      sum = '0;
      for (int ch = 0; ch < NCH; ch++)
        sum = sum + part_q[(ch*4+o)*ACC_W +: ACC_W];
      cl[o] = PIX_W'(clamp_pix(CLAMP_W'(sum), PIX_W));
    end
`ifdef CONV_POOL_MAX_POOL_EN
    pool_w = cl[0];
    for (int o = 1; o < 4; o++)
      if (cl[o] > pool_w) pool_w = cl[o];
`else
    tot = {2'b00, cl[0]} + {2'b00, cl[1]}
        + {2'b00, cl[2]} + {2'b00, cl[3]};
    pool_w = PIX_W'(tot >> 2);
`endif
  end

  // frame sequencing and pipeline advance; stall holds all
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_go   = 1'b0;
    v0_d    = v0_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    img_d   = img_q;
    part_d  = part_q;
    y_d     = y_q;
    if (!bus.stall) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          rd_go = 1'b1;
          if (cnt_q == LAST) state_d = DRAIN;
          else cnt_d = cnt_q + ADDR_W'(1);
        end
        DRAIN: begin
          if (!(v0_q || v1_q || v2_q)) state_d = DONE;
        end
        DONE: state_d = IDLE;
      endcase
      v0_d = rd_go;
      a0_d = cnt_q;
      v1_d = v0_q;
      a1_d = a0_q;
      if (v0_q) img_d = bus.image;
      v2_d = v1_q;
      a2_d = a1_q;
      if (v1_q) part_d = part_w;
      v3_d = v2_q;
      if (v2_q) begin
        a3_d = a2_q;
        y_d  = pool_w;
      end
    end
  end

  // state and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      img_q   <= '0;
      part_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      a3_q    <= a3_d;
      img_q   <= img_d;
      part_q  <= part_d;
      y_q     <= y_d;
    end
  end

  assign bus.rd_en   = (state_q == RUN) && !bus.stall;
  assign bus.rd_addr = cnt_q;
  assign bus.wr_en   = v3_q && !bus.stall;
  assign bus.wr_addr = a3_q;
  assign bus.y       = y_q;
  assign bus.busy    = (state_q == RUN) ||
                       (state_q == DRAIN);
  assign bus.done    = (state_q == DONE) && !bus.stall;

endmodule

// File: tb/tb_conv_pool_pipe.sv
// Bench for conv_pool_pipe: 4-tile and 8-tile instances,
// tile memory model and arithmetic reference model.
module tb_conv_pool_pipe;
  import conv_pool_pkg::*;

  localparam int NCH = 3;
  localparam int PIX_W = 8;
  localparam int KW = 8;
  localparam int ADDR_W = 16;
  localparam int TW = NCH * 16 * PIX_W;
  localparam int KWW = NCH * 9 * KW;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic [KWW-1:0] kernel;
  logic [TW-1:0] mem [8];
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  int st_cyc;
  int wa4[$], wy4[$], wc4[$], rc4[$], dc4[$];
  int wa8[$], wy8[$], wc8[$], rc8[$], dc8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_pool_if #(.NCH(NCH), .PIX_W(PIX_W), .KW(KW),
    .ADDR_W(ADDR_W)) b4 ();
  conv_pool_if #(.NCH(NCH), .PIX_W(PIX_W), .KW(KW),
    .ADDR_W(ADDR_W)) b8 ();

  assign b4.stall = stall;
  assign b8.stall = stall;
  assign b4.kernel = kernel;
  assign b8.kernel = kernel;

  conv_pool_pipe #(.NCH(NCH), .PIX_W(PIX_W), .KW(KW),
    .ADDR_W(ADDR_W), .NUM_TILES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4));
  conv_pool_pipe #(.NCH(NCH), .PIX_W(PIX_W), .KW(KW),
    .ADDR_W(ADDR_W), .NUM_TILES(8)) dut8 (
    .clk(clk), .rst(rst), .bus(b8));

  // tile memory: data one unstalled cycle after the request
  always @(posedge clk) begin
    if (!stall) begin
      if (b4.rd_en) b4.image <= mem[b4.rd_addr[2:0]];
      if (b8.rd_en) b8.image <= mem[b8.rd_addr[2:0]];
    end
  end

  // record traffic away from the active edge
  always @(negedge clk) begin
    if (b4.wr_en) begin
      wa4.push_back(int'(b4.wr_addr));
      wy4.push_back(int'(b4.y));
      wc4.push_back(cyc);
    end
    if (b4.rd_en) rc4.push_back(cyc);
    if (b4.done) dc4.push_back(cyc);
    if (b8.wr_en) begin
      wa8.push_back(int'(b8.wr_addr));
      wy8.push_back(int'(b8.y));
      wc8.push_back(cyc);
    end
    if (b8.rd_en) rc8.push_back(cyc);
    if (b8.done) dc8.push_back(cyc);
  end

  function automatic int ref_y(input int t);
    int v[4];
    int s, px, kc, res;
    logic signed [KW-1:0] kv;
    logic [TW-1:0] tile;
    tile = mem[t];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < NCH; k++)
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
              px = int'(tile[(k*16+(r+i)*4+c+j)*PIX_W +: PIX_W]);
              kv = kernel[(k*9+r*3+c)*KW +: KW];
              kc = kv;
              s += px * kc;
            end
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        v[i*2+j] = s;
      end
`ifdef CONV_POOL_MAX_POOL_EN
    res = v[0];
    for (int o = 1; o < 4; o++) if (v[o] > res) res = v[o];
`else
    res = (v[0] + v[1] + v[2] + v[3]) / 4;
`endif
    return res;
  endfunction

  task automatic fill(input int m);
    int val, kv;
    for (int t = 0; t < 8; t++)
      for (int k = 0; k < NCH; k++)
        for (int p = 0; p < 16; p++) begin
          case (m)
            0: val = 100;
            1: begin
              val = int'($urandom_range(0, 255));
              if (k == 0 && p == 5) val = 10;
              if (k == 0 && p == 6) val = 20;
              if (k == 0 && p == 9) val = 30;
              if (k == 0 && p == 10) val = 40;
            end
            2: val = 200;
            default: val = int'($urandom_range(0, 40));
          endcase
          mem[t][(k*16+p)*PIX_W +: PIX_W] = PIX_W'(val);
        end
    for (int k = 0; k < NCH; k++)
      for (int q = 0; q < 9; q++) begin
        case (m)
          0: kv = (q == 4) ? 1 : 0;
          1: kv = (k == 0 && q == 4) ? 1 : 0;
          2: kv = -1;
          default: kv = int'($urandom_range(0, 7)) - 3;
        endcase
        kernel[(k*9+q)*KW +: KW] = KW'(kv);
      end
  endtask

  task automatic clear_q();
    wa4.delete(); wy4.delete(); wc4.delete();
    rc4.delete(); dc4.delete();
    wa8.delete(); wy8.delete(); wc8.delete();
    rc8.delete(); dc8.delete();
  endtask

  task automatic pulse_start(input bit big);
    @(posedge clk); #1;
    if (big) b8.start = 1'b1;
    else b4.start = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    b4.start = 1'b0;
    b8.start = 1'b0;
  endtask

  task automatic wait_done(input bit big, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = big ? (dc8.size() > 0) : (dc4.size() > 0);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    nvec++; if (b8.rd_en !== 1'b0) begin nerr++; $display("FAIL rst_rd_en: got %0b want 0", b8.rd_en); end
    nvec++; if (b8.rd_addr !== '0) begin nerr++; $display("FAIL rst_rd_addr: got %0d want 0", b8.rd_addr); end
    nvec++; if (b8.wr_en !== 1'b0) begin nerr++; $display("FAIL rst_wr_en: got %0b want 0", b8.wr_en); end
    nvec++; if (b8.wr_addr !== '0) begin nerr++; $display("FAIL rst_wr_addr: got %0d want 0", b8.wr_addr); end
    nvec++; if (b8.y !== '0) begin nerr++; $display("FAIL rst_y: got %0d want 0", b8.y); end
    nvec++; if (b8.busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %0b want 0", b8.busy); end
    nvec++; if (b8.done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %0b want 0", b8.done); end
    nvec++; if ({b4.rd_en, b4.wr_en, b4.y, b4.busy} !== '0) begin nerr++; $display("FAIL rst_dut4: got %0h want 0", {b4.rd_en, b4.wr_en, b4.y, b4.busy}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // centre-only, channel-0 centre and all-negative kernels
  task automatic test_patterns();
    bit ok;
    int n, cst;
    for (int m = 0; m < 3; m++) begin
      fill(m);
      clear_q();
      pulse_start(1'b0);
      nvec++; if (b4.busy !== 1'b1) begin nerr++; $display("FAIL pat%0d_busy: got %0b want 1", m, b4.busy); end
      wait_done(1'b0, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL pat%0d_timeout: got 0 want 1", m); end
`ifdef CONV_POOL_MAX_POOL_EN
      cst = (m == 0) ? 255 : (m == 1) ? 40 : 0;
`else
      cst = (m == 0) ? 255 : (m == 1) ? 25 : 0;
`endif
      n = wa4.size();
      nvec++; if (n !== 4) begin nerr++; $display("FAIL pat%0d_count: got %0d want 4", m, n); end
      for (int k = 0; k < n && k < 4; k++) begin
        nvec++; if (wa4[k] !== k) begin nerr++; $display("FAIL pat%0d_addr: got %0d want %0d", m, wa4[k], k); end
        nvec++; if (wy4[k] !== cst) begin nerr++; $display("FAIL pat%0d_y: got %0d want %0d", m, wy4[k], cst); end
        nvec++; if (wy4[k] !== ref_y(k)) begin nerr++; $display("FAIL pat%0d_model: got %0d want %0d", m, wy4[k], ref_y(k)); end
        nvec++; if (wc4[k] !== wc4[0] + k) begin nerr++; $display("FAIL pat%0d_gap: got %0d want %0d", m, wc4[k], wc4[0] + k); end
      end
      if (n > 0 && rc4.size() > 0) begin
        nvec++; if (wc4[0] - rc4[0] !== 4) begin nerr++; $display("FAIL pat%0d_latency: got %0d want 4", m, wc4[0] - rc4[0]); end
      end
      nvec++; if (dc4.size() !== 1) begin nerr++; $display("FAIL pat%0d_done_cnt: got %0d want 1", m, dc4.size()); end
      if (n > 0 && dc4.size() > 0) begin
        nvec++; if (dc4[0] !== wc4[n-1] + 1) begin nerr++; $display("FAIL pat%0d_done_at: got %0d want %0d", m, dc4[0], wc4[n-1] + 1); end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int f = 0; f < 3; f++) begin
      fill(3);
      clear_q();
      pulse_start(1'b1);
      wait_done(1'b1, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL rnd%0d_timeout: got 0 want 1", f); end
      n = wa8.size();
      nvec++; if (n !== 8) begin nerr++; $display("FAIL rnd%0d_count: got %0d want 8", f, n); end
      for (int k = 0; k < n && k < 8; k++) begin
        nvec++; if (wa8[k] !== k) begin nerr++; $display("FAIL rnd%0d_addr: got %0d want %0d", f, wa8[k], k); end
        nvec++; if (wy8[k] !== ref_y(k)) begin nerr++; $display("FAIL rnd%0d_y: got %0d want %0d", f, wy8[k], ref_y(k)); end
      end
      if (dc8.size() > 0) begin
        nvec++; if (dc8[0] - st_cyc !== 13) begin nerr++; $display("FAIL rnd%0d_done_at: got %0d want 13", f, dc8[0] - st_cyc); end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    fill(3);
    clear_q();
    pulse_start(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    stall = 1'b0;
    wait_done(1'b1, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL stall_timeout: got 0 want 1"); end
    n = wa8.size();
    nvec++; if (n !== 8) begin nerr++; $display("FAIL stall_count: got %0d want 8", n); end
    nvec++; if (rc8.size() !== 8) begin nerr++; $display("FAIL stall_reads: got %0d want 8", rc8.size()); end
    for (int k = 0; k < n && k < 8; k++) begin
      nvec++; if (wa8[k] !== k) begin nerr++; $display("FAIL stall_addr: got %0d want %0d", wa8[k], k); end
      nvec++; if (wy8[k] !== ref_y(k)) begin nerr++; $display("FAIL stall_y: got %0d want %0d", wy8[k], ref_y(k)); end
    end
    if (rc8.size() > 2) begin
      nvec++; if (rc8[2] - st_cyc !== 6) begin nerr++; $display("FAIL stall_rd3_at: got %0d want 6", rc8[2] - st_cyc); end
    end
    if (dc8.size() > 0) begin
      nvec++; if (dc8[0] - st_cyc !== 16) begin nerr++; $display("FAIL stall_done_at: got %0d want 16", dc8[0] - st_cyc); end
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int n;
    fill(3);
    clear_q();
    pulse_start(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    nvec++; if (b8.rd_en !== 1'b0) begin nerr++; $display("FAIL mid_rd_en: got %0b want 0", b8.rd_en); end
    nvec++; if (b8.rd_addr !== '0) begin nerr++; $display("FAIL mid_rd_addr: got %0d want 0", b8.rd_addr); end
    nvec++; if (b8.busy !== 1'b0) begin nerr++; $display("FAIL mid_busy: got %0b want 0", b8.busy); end
    nvec++; if (b8.y !== '0) begin nerr++; $display("FAIL mid_y: got %0d want 0", b8.y); end
    nvec++; if (b8.wr_addr !== '0) begin nerr++; $display("FAIL mid_wr_addr: got %0d want 0", b8.wr_addr); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    nvec++; if (rc8.size() !== 2) begin nerr++; $display("FAIL mid_reads: got %0d want 2", rc8.size()); end
    nvec++; if (wa8.size() !== 0) begin nerr++; $display("FAIL mid_writes: got %0d want 0", wa8.size()); end
    clear_q();
    pulse_start(1'b1);
    wait_done(1'b1, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL mid_timeout: got 0 want 1"); end
    n = wa8.size();
    nvec++; if (n !== 8) begin nerr++; $display("FAIL mid_count: got %0d want 8", n); end
    for (int k = 0; k < n && k < 8; k++) begin
      nvec++; if (wa8[k] !== k) begin nerr++; $display("FAIL mid_addr: got %0d want %0d", wa8[k], k); end
      nvec++; if (wy8[k] !== ref_y(k)) begin nerr++; $display("FAIL mid_y_out: got %0d want %0d", wy8[k], ref_y(k)); end
    end
  endtask

  task automatic test_start_ignored();
    int n;
    fill(3);
    clear_q();
    pulse_start(1'b1);
    @(posedge clk); #1;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    for (int i = 0; i < 40 && cyc < st_cyc + 13; i++) begin
      @(posedge clk); #1;
    end
    nvec++; if (b8.done !== 1'b1) begin nerr++; $display("FAIL ign_done_now: got %0b want 1", b8.done); end
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (30) @(negedge clk);
    n = wa8.size();
    nvec++; if (n !== 8) begin nerr++; $display("FAIL ign_count: got %0d want 8", n); end
    nvec++; if (rc8.size() !== 8) begin nerr++; $display("FAIL ign_reads: got %0d want 8", rc8.size()); end
    nvec++; if (dc8.size() !== 1) begin nerr++; $display("FAIL ign_done_cnt: got %0d want 1", dc8.size()); end
    nvec++; if (b8.busy !== 1'b0) begin nerr++; $display("FAIL ign_busy: got %0b want 0", b8.busy); end
    for (int k = 0; k < n && k < 8; k++) begin
      nvec++; if (wa8[k] !== k) begin nerr++; $display("FAIL ign_addr: got %0d want %0d", wa8[k], k); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    b4.start = 1'b0;
    b8.start = 1'b0;
    kernel = '0;
    for (int t = 0; t < 8; t++) mem[t] = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_patterns();
    test_random();
    test_stall();
    test_rst_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==",
      nvec, nerr);
    $finish;
  end

endmodule
